// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state encodings, opcode/funct constants, ALU operation
// codes, PC source selects and the instruction-class enumeration used by
// instr_class_decode and multicycle_controller.
package multicycle_controller_pkg;

  // FSM state encodings
  localparam int          ST_W      = 3;
  localparam logic [2:0]  ST_FETCH  = 3'd0;
  localparam logic [2:0]  ST_DECODE = 3'd1;
  localparam logic [2:0]  ST_EXEC   = 3'd2;
  localparam logic [2:0]  ST_MEM    = 3'd3;
  localparam logic [2:0]  ST_WB     = 3'd4;
  localparam logic [2:0]  ST_NOC_TX = 3'd5;
  localparam logic [2:0]  ST_NOC_RX = 3'd6;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_NOC_TX = 6'b110000;
  localparam logic [5:0] OP_NOC_RX = 6'b110001;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes (zero-extended to ALUOP_W at the top level)
  localparam int         ALU_CODE_W = 4;
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  // PC source selects
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction classes
  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_RTYPE   = 4'd1,
    CLS_ADDI    = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_LOAD    = 4'd4,
    CLS_STORE   = 4'd5,
    CLS_BEQ     = 4'd6,
    CLS_JUMP    = 4'd7,
    CLS_NOC_TX  = 4'd8,
    CLS_NOC_RX  = 4'd9,
    CLS_ILLEGAL = 4'd10
  } iclass_e;

endpackage

// File: rtl/multicycle_controller_instr_class_decode.sv
// Combinational instruction classifier.
// Maps the IR opcode/funct fields to an instruction class and a 4-bit ALU
// operation code. Unknown opcodes map to CLS_ILLEGAL with ALU_NOP.
// Ports:
//   opcode_i  [5:0]  opcode field
//   funct_i   [5:0]  funct field (only meaningful for R-type)
//   iclass_o         instruction class
//   aluop_o   [3:0]  ALU operation code for the EXEC state
module instr_class_decode
  import multicycle_controller_pkg::*;
(
  input  logic [5:0]            opcode_i,
  input  logic [5:0]            funct_i,
  output iclass_e               iclass_o,
  output logic [ALU_CODE_W-1:0] aluop_o
);

  always_comb begin
    iclass_o = CLS_ILLEGAL;
    aluop_o  = ALU_NOP;
    case (opcode_i)
      OP_RTYPE: begin
        iclass_o = CLS_RTYPE;
        case (funct_i)
          FN_ADD:  aluop_o = ALU_ADD;
          FN_SUB:  aluop_o = ALU_SUB;
          FN_AND:  aluop_o = ALU_AND;
          FN_OR:   aluop_o = ALU_OR;
          FN_SLT:  aluop_o = ALU_SLT;
          default: aluop_o = ALU_NOP;
        endcase
      end
      OP_ADDI: begin
        iclass_o = CLS_ADDI;
        aluop_o  = ALU_ADD;
      end
      OP_LUI: begin
        iclass_o = CLS_LUI;
        aluop_o  = ALU_LUI;
      end
      OP_LW, OP_LB: begin
        iclass_o = CLS_LOAD;
        aluop_o  = ALU_ADD;
      end
      OP_SW, OP_SB: begin
        iclass_o = CLS_STORE;
        aluop_o  = ALU_ADD;
      end
      OP_BEQ: begin
        iclass_o = CLS_BEQ;
        aluop_o  = ALU_SUB;
      end
      OP_J:      iclass_o = CLS_JUMP;
      OP_NOC_TX: iclass_o = CLS_NOC_TX;
      OP_NOC_RX: iclass_o = CLS_NOC_RX;
      default:   iclass_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller with NoC send/receive instructions.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   opcode, funct               IR fields, sampled only in DECODE
//   zero                        ALU zero flag (branch decision in EXEC)
//   noc_tx_ready/noc_rx_valid   per-channel NoC handshake inputs
//   pcWrite..regWrite, ALUOp,
//   pcSrc                       datapath controls
//   noc_tx_valid/noc_rx_ready   one-hot NoC handshake outputs
//   illegal                     pulse in DECODE for an unknown opcode
//   stall_cnt                   saturating count of NoC stall cycles
//
// NoC handshake: a transfer on channel ch completes in the cycle where
// both the controller's request bit [ch] and the partner's bit [ch] are 1.
// The request is held every cycle until that happens; partner bits on other
// channels are ignored.
//
// Every output is forced to 0 while rst is high, so an instruction caught
// by reset drops its handshake in the reset cycle itself.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int NOC_CH  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic [NOC_CH-1:0]  noc_tx_ready,
  input  logic [NOC_CH-1:0]  noc_rx_valid,
  output logic               pcWrite,
  output logic               irWrite,
  output logic               regDst,
  output logic               memRead,
  output logic               memWrite,
  output logic               memtoReg,
  output logic               nocToReg,
  output logic               ALUSrc,
  output logic               regWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         pcSrc,
  output logic [NOC_CH-1:0]  noc_tx_valid,
  output logic [NOC_CH-1:0]  noc_rx_ready,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int CH_W = (NOC_CH > 1) ? $clog2(NOC_CH) : 1;

  logic [ST_W-1:0]       state_q, state_d;
  iclass_e               cls_q, cls_d;
  logic [ALU_CODE_W-1:0] alu_q, alu_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  iclass_e               dec_cls;
  logic [ALU_CODE_W-1:0] dec_alu;
  logic [CH_W-1:0]       dec_ch;
  logic [NOC_CH-1:0]     ch_onehot;
  logic                  tx_hs, rx_hs;
  logic [ALU_CODE_W-1:0] alu_code;

  instr_class_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .iclass_o (dec_cls),
    .aluop_o  (dec_alu)
  );

  // With a single channel there are no channel-select bits in funct.
  assign dec_ch    = (NOC_CH == 1) ? '0 : funct[CH_W-1:0];
  assign ch_onehot = NOC_CH'(1) << ch_q;
  assign tx_hs     = |(noc_tx_ready & ch_onehot);
  assign rx_hs     = |(noc_rx_valid & ch_onehot);

  // Next-state, decode capture and stall counter
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = dec_cls;
        alu_d = dec_alu;
        ch_d  = dec_ch;
        case (dec_cls)
          CLS_NOC_TX:  state_d = ST_NOC_TX;
          CLS_NOC_RX:  state_d = ST_NOC_RX;
          CLS_ILLEGAL: state_d = ST_FETCH;
          default:     state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_RTYPE, CLS_ADDI, CLS_LUI: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:          state_d = ST_MEM;
          default:                      state_d = ST_FETCH;
        endcase
      end
      ST_MEM:  state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_NOC_TX: begin
        if (tx_hs) begin
          state_d = ST_FETCH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NOC_RX: begin
        if (rx_hs) begin
          state_d = ST_FETCH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
      alu_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode. Moore on state/registered class, except: pcWrite follows
  // zero for beq, regWrite/nocToReg follow the receive handshake, and
  // illegal follows the live opcode in DECODE.
  always_comb begin
    pcWrite      = 1'b0;
    irWrite      = 1'b0;
    regDst       = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memtoReg     = 1'b0;
    nocToReg     = 1'b0;
    ALUSrc       = 1'b0;
    regWrite     = 1'b0;
    alu_code     = ALU_NOP;
    pcSrc        = PCSRC_SEQ;
    noc_tx_valid = '0;
    noc_rx_ready = '0;
    illegal      = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          memRead  = 1'b1;
          irWrite  = 1'b1;
          pcWrite  = 1'b1;
          alu_code = ALU_ADD;
        end
        ST_DECODE: illegal = (dec_cls == CLS_ILLEGAL);
        ST_EXEC: begin
          case (cls_q)
            CLS_RTYPE: alu_code = alu_q;
            CLS_ADDI, CLS_LUI, CLS_LOAD, CLS_STORE: begin
              alu_code = alu_q;
              ALUSrc   = 1'b1;
            end
            CLS_BEQ: begin
              alu_code = ALU_SUB;
              pcSrc    = PCSRC_BRANCH;
              pcWrite  = zero;
            end
            CLS_JUMP: begin
              pcSrc   = PCSRC_JUMP;
              pcWrite = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          memRead  = (cls_q == CLS_LOAD);
          memWrite = (cls_q == CLS_STORE);
        end
        ST_WB: begin
          regWrite = 1'b1;
          regDst   = (cls_q == CLS_RTYPE);
          memtoReg = (cls_q == CLS_LOAD);
        end
        ST_NOC_TX: noc_tx_valid = ch_onehot;
        ST_NOC_RX: begin
          noc_rx_ready = ch_onehot;
          regWrite     = rx_hs;
          nocToReg     = rx_hs;
        end
        default: ;
      endcase
    end
    ALUOp = ALUOP_W'(alu_code);
  end

  assign stall_cnt = rst ? '0 : cnt_q;

endmodule
